// File: rtl/gauss5_filter.sv
// Separable 5x5 Gaussian smoother: vertical 5-tap, horizontal 5-tap, >>16 with saturation.
// One output per input pixel; the two border columns on each side of a line are forced to zero.
module gauss5_filter #(
   parameter int unsigned   DW   = 8,
   parameter int unsigned   RW   = 32,
   parameter int unsigned   RD   = 8,
   parameter logic [RW-1:0] BASE = 32'h43C1_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fsync,
   input  logic            hsync,
   input  logic [5*DW-1:0] din_col,
   input  logic            reg_wea,
   input  logic [RW-1:0]   reg_addra,
   input  logic [RD-1:0]   reg_wdata,
   output logic [DW-1:0]   dout,
   output logic            dout_valid,
   output logic            fsync_o,
   output logic            line_err
);
   localparam int unsigned VW = DW + RD + 3;
   localparam int unsigned HW = VW + RD + 3;
   localparam int unsigned NW = HW - 16;
   localparam int unsigned XW = 16;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LINE   = 2'd1;
   localparam logic [1:0] S_FLUSH1 = 2'd2;
   localparam logic [1:0] S_FLUSH2 = 2'd3;

   function automatic logic [RD-1:0] coef_default(input int k);
      case (k)
         0, 4:    coef_default = RD'(6);
         1, 3:    coef_default = RD'(59);
         default: coef_default = RD'(128);
      endcase
   endfunction

   logic [RD-1:0] coef [5];
   logic [RD-1:0] shadow [5];
   logic [1:0]    state, state_nxt;
   logic [XW-1:0] x, x_nxt, x_inc;
   logic          hsync_d, fsync_d, fs_rise;
   logic          pix, flush, emit, zero, err_set;
   logic [VW-1:0] vsum;
   logic [VW-1:0] win [5];
   logic [HW-1:0] hsum;
   logic [NW-1:0] h_q;
   logic          e1, z1, e2, z2;
   logic [3:0]    fsync_pipe;

   assign fs_rise = fsync & ~fsync_d;
   assign x_inc   = (x == '1) ? x : x + XW'(1);

   // Emit tags: a pixel at column x emits output x-2; each flush cycle emits one trailing output.
   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      pix       = 1'b0;
      flush     = 1'b0;
      emit      = 1'b0;
      zero      = 1'b0;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (hsync && !hsync_d) begin
               state_nxt = S_LINE;
               pix       = 1'b1;
               x_nxt     = XW'(1);
            end
         end
         S_LINE: begin
            if (hsync) begin
               pix   = 1'b1;
               x_nxt = x_inc;
               emit  = (x >= XW'(2));
               zero  = (x < XW'(4));
            end else begin
               state_nxt = S_FLUSH1;
            end
         end
         S_FLUSH1, S_FLUSH2: begin
            if (hsync) begin
               // New line arrived before the flush finished: pending trailing outputs are lost.
               state_nxt = S_LINE;
               pix       = 1'b1;
               x_nxt     = XW'(1);
               err_set   = 1'b1;
            end else begin
               flush     = 1'b1;
               zero      = 1'b1;
               emit      = (state == S_FLUSH2) || (x >= XW'(2));
               state_nxt = (state == S_FLUSH1) ? S_FLUSH2 : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (!fsync) begin
         state_nxt = S_IDLE;
         x_nxt     = '0;
         pix       = 1'b0;
         flush     = 1'b0;
         emit      = 1'b0;
         err_set   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         x       <= '0;
         hsync_d <= 1'b1;
         fsync_d <= 1'b1;
      end else begin
         state   <= state_nxt;
         x       <= x_nxt;
         hsync_d <= hsync;
         fsync_d <= fsync;
      end
   end

   // Shadow coefficients take bus writes; the active set swaps in at frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 5; k++) begin
            coef[k]   <= coef_default(k);
            shadow[k] <= coef_default(k);
         end
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (reg_wea && reg_addra == BASE + RW'(k)) shadow[k] <= reg_wdata;
            if (fs_rise) coef[k] <= shadow[k];
         end
      end
   end

   always_comb begin
      vsum = '0;
      for (int k = 0; k < 5; k++)
         vsum = vsum + VW'(coef[k]) * VW'(din_col[k*DW +: DW]);
   end

   always_comb begin
      hsum = '0;
      for (int k = 0; k < 5; k++)
         hsum = hsum + HW'(coef[k]) * HW'(win[4-k]);
   end

   // win[0] is the vertical stage register; win[4] holds the oldest column.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 5; k++) win[k] <= '0;
      end else if (pix || flush) begin
         win[0] <= pix ? vsum : '0;
         for (int k = 1; k < 5; k++) win[k] <= win[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e1         <= 1'b0;
         z1         <= 1'b0;
         e2         <= 1'b0;
         z2         <= 1'b0;
         h_q        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         fsync_pipe <= '0;
         fsync_o    <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         e1         <= emit;
         z1         <= zero;
         e2         <= e1;
         z2         <= z1;
         h_q        <= NW'(hsum >> 16);
         dout_valid <= e2;
         if (z2)
            dout <= '0;
         else if (|h_q[NW-1:DW])
            dout <= '1;
         else
            dout <= h_q[DW-1:0];
         fsync_pipe <= {fsync_pipe[2:0], fsync};
         fsync_o    <= fsync_pipe[3];
         if (fs_rise) line_err <= 1'b0;
         if (err_set) line_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_gauss5_filter.sv
// Bench for gauss5_filter: random and directed frames against a plain-arithmetic
// separable 5x5 reference computed per line from the column buffer.
module tb_gauss5_filter;
   localparam logic [31:0] BASE = 32'h43C1_0000;

   logic        clk = 1'b0, rst = 1'b1, fsync = 1'b0, hsync = 1'b0, reg_wea = 1'b0;
   logic [39:0] din_col = '0;
   logic [31:0] reg_addra = '0;
   logic [7:0]  reg_wdata = '0;
   logic [7:0]  dout;
   logic        dout_valid, fsync_o, line_err;

   int          n_cmp = 0, n_bad = 0, cyc = 0, mark_cyc = 0;
   logic [7:0]  colbuf [64][5];
   int          m_act [5];
   int          m_shd [5];
   logic [7:0]  exp_q [$];
   logic [7:0]  cap [$];
   int          cap_cyc [$];

   gauss5_filter dut (
      .clk(clk), .rst(rst), .fsync(fsync), .hsync(hsync), .din_col(din_col),
      .reg_wea(reg_wea), .reg_addra(reg_addra), .reg_wdata(reg_wdata),
      .dout(dout), .dout_valid(dout_valid), .fsync_o(fsync_o), .line_err(line_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (dout_valid) begin cap.push_back(dout); cap_cyc.push_back(cyc); end

   function automatic logic [39:0] pack(input int x);
      logic [39:0] p;
      for (int r = 0; r < 5; r++) p[r*8 +: 8] = colbuf[x][r];
      return p;
   endfunction

   task automatic model_defaults();
      m_act = '{6, 59, 128, 59, 6};
      m_shd = '{6, 59, 128, 59, 6};
   endtask

   // Reference: zero at the two border columns each side, else (sum ck*sum cj*p)>>16 saturated.
   task automatic model_line(input int w, input bit drop_last);
      longint h, v;
      for (int i = 0; i < w; i++) begin
         h = 0;
         if (i >= 2 && i <= w - 3) begin
            for (int k = 0; k < 5; k++) begin
               v = 0;
               for (int j = 0; j < 5; j++) v += m_act[j] * int'(colbuf[i-2+k][j]);
               h += m_act[k] * v;
            end
            h = h >> 16;
            if (h > 255) h = 255;
         end
         if (!(drop_last && i == w - 1)) exp_q.push_back(8'(h));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input int w, input int mark_x);
      for (int x = 0; x < w; x++) begin
         step();
         hsync = 1'b1;
         din_col = pack(x);
         if (x == mark_x) mark_cyc = cyc;
      end
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         hsync = 1'b0;
         din_col = '0;
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
      step();
      reg_wea = 1'b1; reg_addra = addr; reg_wdata = data;
      step();
      reg_wea = 1'b0;
      if (addr >= BASE && addr <= BASE + 32'd4) m_shd[int'(addr - BASE)] = int'(data);
   endtask

   task automatic frame_start();
      step(); fsync = 1'b0;
      step(); fsync = 1'b1;
      m_act = m_shd;
   endtask

   task automatic fill_flat(input int w, input int val);
      for (int x = 0; x < w; x++) for (int r = 0; r < 5; r++) colbuf[x][r] = 8'(val);
   endtask

   task automatic fill_rand(input int w);
      for (int x = 0; x < w; x++) for (int r = 0; r < 5; r++) colbuf[x][r] = 8'($urandom_range(0, 255));
   endtask

   task automatic test_reset();
      model_defaults();
      repeat (3) step();
      n_cmp += 4;
      if (dout !== 8'd0)      begin n_bad++; $display("FAIL reset_dout got %0d want 0", dout); end
      if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
      if (fsync_o !== 1'b0)   begin n_bad++; $display("FAIL reset_fsync_o got %b want 0", fsync_o); end
      if (line_err !== 1'b0)  begin n_bad++; $display("FAIL reset_line_err got %b want 0", line_err); end
      rst = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_flat();
      cap.delete(); exp_q.delete();
      fill_flat(16, 100);
      step(); fsync = 1'b1; m_act = m_shd;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (fsync_o !== (k == 5)) begin n_bad++; $display("FAIL fsync_o_delay[%0d] got %b want %b", k, fsync_o, k == 5); end
      end
      for (int l = 0; l < 8; l++) begin drive_line(16, -1); blank(3); model_line(16, 0); end
      blank(12);
      n_cmp++;
      if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL flat_count got %0d want %0d", cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         n_cmp++;
         if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL flat_px[%0d] got %0d want %0d", i, cap[i], exp_q[i]); end
      end
      n_cmp += 2;
      if (cap.size() < 9 || cap[8] !== 8'd101) begin n_bad++; $display("FAIL flat_interior got %0d want 101", cap.size() > 8 ? cap[8] : 0); end
      if (line_err !== 1'b0) begin n_bad++; $display("FAIL flat_line_err got %b want 0", line_err); end
   endtask

   task automatic test_saturation();
      cap.delete(); exp_q.delete();
      fill_flat(16, 255);
      frame_start();
      for (int l = 0; l < 2; l++) begin drive_line(16, -1); blank(4); model_line(16, 0); end
      blank(12);
      n_cmp++;
      if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL sat_count got %0d want %0d", cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         n_cmp++;
         if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL sat_px[%0d] got %0d want %0d", i, cap[i], exp_q[i]); end
      end
      n_cmp++;
      if (cap.size() < 6 || cap[5] !== 8'd255) begin n_bad++; $display("FAIL sat_interior got %0d want 255", cap.size() > 5 ? cap[5] : 0); end
   endtask

   task automatic test_impulse();
      cap.delete(); exp_q.delete(); cap_cyc.delete();
      fill_flat(16, 0);
      colbuf[7][2] = 8'd255;
      frame_start();
      drive_line(16, 7); blank(12); model_line(16, 0);
      n_cmp++;
      if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL imp_count got %0d want %0d", cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         n_cmp++;
         if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL imp_px[%0d] got %0d want %0d", i, cap[i], exp_q[i]); end
      end
      if (cap.size() == 16) begin
         n_cmp += 3;
         if (cap[7] !== 8'd63) begin n_bad++; $display("FAIL imp_centre got %0d want 63", cap[7]); end
         if (cap[6] !== 8'd29) begin n_bad++; $display("FAIL imp_side got %0d want 29", cap[6]); end
         if (cap_cyc[7] - mark_cyc !== 5) begin n_bad++; $display("FAIL imp_latency got %0d want 5", cap_cyc[7] - mark_cyc); end
      end
   endtask

   task automatic test_shadow();
      cap.delete(); exp_q.delete();
      fill_flat(16, 100);
      frame_start();
      drive_line(16, -1); blank(1); model_line(16, 0);
      bus_write(BASE + 32'd2, 8'd64);
      bus_write(BASE + 32'd5, 8'd0);
      bus_write(BASE - 32'd1, 8'd0);
      drive_line(16, -1); blank(12); model_line(16, 0);
      frame_start();
      for (int l = 0; l < 2; l++) begin drive_line(16, -1); blank(3); model_line(16, 0); end
      blank(12);
      n_cmp++;
      if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL shadow_count got %0d want %0d", cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         n_cmp++;
         if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL shadow_px[%0d] got %0d want %0d", i, cap[i], exp_q[i]); end
      end
      if (cap.size() == 64) begin
         n_cmp += 2;
         if (cap[24] !== 8'd101) begin n_bad++; $display("FAIL shadow_old_frame got %0d want 101", cap[24]); end
         if (cap[40] !== 8'd57)  begin n_bad++; $display("FAIL shadow_new_frame got %0d want 57", cap[40]); end
      end
   endtask

   task automatic test_short_blank();
      cap.delete(); exp_q.delete();
      fill_flat(16, 100);
      frame_start();
      drive_line(16, -1); blank(2); model_line(16, 1);
      drive_line(16, -1); blank(12); model_line(16, 0);
      n_cmp++;
      if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL short_count got %0d want %0d", cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         n_cmp++;
         if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL short_px[%0d] got %0d want %0d", i, cap[i], exp_q[i]); end
      end
      n_cmp++;
      if (line_err !== 1'b1) begin n_bad++; $display("FAIL short_line_err_set got %b want 1", line_err); end
      frame_start();
      step();
      @(negedge clk);
      n_cmp++;
      if (line_err !== 1'b0) begin n_bad++; $display("FAIL short_line_err_clear got %b want 0", line_err); end
   endtask

   task automatic test_reset_midline();
      exp_q.delete();
      fill_flat(16, 100);
      frame_start();
      for (int x = 0; x < 16; x++) begin
         step();
         hsync = 1'b1;
         din_col = pack(x);
         if (x == 6) begin
            rst = 1'b1;
            #1;
            cap.delete();
            model_defaults();
            n_cmp += 4;
            if (dout !== 8'd0)       begin n_bad++; $display("FAIL rstmid_dout got %0d want 0", dout); end
            if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", dout_valid); end
            if (fsync_o !== 1'b0)    begin n_bad++; $display("FAIL rstmid_fsync_o got %b want 0", fsync_o); end
            if (line_err !== 1'b0)   begin n_bad++; $display("FAIL rstmid_line_err got %b want 0", line_err); end
         end
         if (x == 8) rst = 1'b0;
      end
      blank(10);
      n_cmp++;
      if (cap.size() !== 0) begin n_bad++; $display("FAIL rstmid_partial got %0d outputs want 0", cap.size()); end
      cap.delete();
      drive_line(16, -1); blank(12); model_line(16, 0);
      n_cmp++;
      if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL rstmid_count got %0d want %0d", cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         n_cmp++;
         if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_px[%0d] got %0d want %0d", i, cap[i], exp_q[i]); end
      end
      n_cmp++;
      if (cap.size() < 9 || cap[8] !== 8'd101) begin n_bad++; $display("FAIL rstmid_default_coef got %0d want 101", cap.size() > 8 ? cap[8] : 0); end
   endtask

   task automatic test_random();
      int w;
      for (int f = 0; f < 4; f++) begin
         cap.delete(); exp_q.delete();
         for (int k = 0; k < 5; k++) bus_write(BASE + 32'(k), 8'($urandom_range(0, 255)));
         bus_write(BASE + 32'd5 + 32'($urandom_range(0, 100)), 8'($urandom_range(0, 255)));
         frame_start();
         for (int l = 0; l < 5; l++) begin
            w = (l == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 24));
            fill_rand(w);
            drive_line(w, -1);
            blank(int'($urandom_range(3, 6)));
            model_line(w, 0);
         end
         blank(12);
         n_cmp++;
         if (cap.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count[%0d] got %0d want %0d", f, cap.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_cmp++;
            if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_px[%0d][%0d] got %0d want %0d", f, i, cap[i], exp_q[i]); end
         end
         n_cmp++;
         if (line_err !== 1'b0) begin n_bad++; $display("FAIL rand_line_err[%0d] got %b want 0", f, line_err); end
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_saturation();
      test_impulse();
      test_shadow();
      test_short_blank();
      test_reset_midline();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
